// File: rtl/minterm_feed_stage.sv
// minterm_feed_stage: small first-word-fall-through FIFO of 2-bit gate operand
// codes {a,b}, presented downstream as a one-hot minterm vector. When
// sweep_en is asserted and the FIFO is empty, the stage instead cycles through
// all four operand combinations on its own.
//
// Ports
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   in_valid    : upstream operand pair present
//   in_ready    : stage accepts the pair this cycle
//   a, b        : gate operands
//   sweep_en    : request an autonomous sweep of all (a,b) combinations
//   out_valid   : i_out carries a valid minterm vector
//   out_ready   : downstream consumes i_out
//   i_out       : one-hot minterm vector, [3]=a&b [2]=a&~b [1]=~a&b [0]=~a&~b
//   level       : current FIFO occupancy
//   sweep_done  : one-cycle pulse after the code-3 sweep entry handshakes
module minterm_feed_stage #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   a,
    input  logic                   b,
    input  logic                   sweep_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             i_out,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sweep_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        ST_FIFO  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [1:0]      sweep_cnt_q, sweep_cnt_d;
    logic            sweep_done_q, sweep_done_d;

    logic            sweep_active;
    logic            full;
    logic            push;
    logic            pop;
    logic            hs;
    logic [1:0]      code;

    // Handshake qualifiers, all derived from registered state. rst gates
    // in_ready so nothing is accepted while the stage is held in reset.
    assign sweep_active = (state_q == ST_SWEEP);
    assign full         = (level_q == LW'(DEPTH));
    assign in_ready     = !rst && !full && !sweep_active;
    assign out_valid    = sweep_active || (level_q != '0);
    assign hs           = out_valid && out_ready;
    assign push         = in_valid && in_ready;
    assign pop          = hs && !sweep_active;

    // Presented code: sweep counter in SWEEP, FIFO head otherwise.
    assign code       = sweep_active ? sweep_cnt_q : mem_q[rd_ptr_q];
    assign i_out      = out_valid ? (4'b0001 << code) : 4'b0000;
    assign level      = level_q;
    assign sweep_done = sweep_done_q;

    // Next-state: mode FSM, sweep counter, FIFO pointers and occupancy.
    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        sweep_done_d = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;

        case (state_q)
            ST_FIFO: begin
                // Only enter the sweep once the FIFO has drained.
                if (sweep_en && (level_q == '0)) begin
                    state_d = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                // A presented code is never withdrawn; exit only on handshake.
                if (hs) begin
                    sweep_cnt_d  = sweep_cnt_q + 2'd1;
                    sweep_done_d = (sweep_cnt_q == 2'd3);
                    if (!sweep_en) begin
                        state_d = ST_FIFO;
                    end
                end
            end
            default: state_d = ST_FIFO;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FIFO;
            sweep_cnt_q  <= 2'd0;
            sweep_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            sweep_done_q <= sweep_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // Storage array; contents are don't-care until written, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {a, b};
        end
    end

endmodule

// File: tb/tb_minterm_feed_stage.sv
// Directed bench for minterm_feed_stage: FIFO ordering, full/empty edges,
// sweep entry/exit/resume, sweep_done pulse and asynchronous reset.
module tb_minterm_feed_stage;

    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   a = 1'b0;
    logic                   b = 1'b0;
    logic                   sweep_en = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [3:0]             i_out;
    logic [$clog2(DEPTH):0] level;
    logic                   sweep_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] sb_q[$];
    logic       m_sweep = 1'b0;
    logic [1:0] m_cnt   = 2'd0;
    logic       m_done  = 1'b0;

    minterm_feed_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sweep_en   (sweep_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .i_out      (i_out),
        .level      (level),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] dec(input logic [1:0] c);
        case (c)
            2'b00:   dec = 4'b0001;
            2'b01:   dec = 4'b0010;
            2'b10:   dec = 4'b0100;
            default: dec = 4'b1000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, update the model with the
    // handshakes that will happen at the next rising edge, then step past it.
    task automatic tick();
        int         size0;
        logic       hs;
        logic       psh;
        logic       exp_valid;
        logic [3:0] exp_out;
        @(negedge clk);
        size0     = sb_q.size();
        exp_valid = m_sweep || (size0 != 0);
        exp_out   = 4'b0000;
        if (m_sweep)        exp_out = dec(m_cnt);
        else if (size0 > 0) exp_out = sb_q[0];

        chk("in_ready",   in_ready,   !m_sweep && (size0 < DEPTH));
        chk("out_valid",  out_valid,  exp_valid);
        chk("level",      32'(level), size0);
        chk("sweep_done", sweep_done, m_done);
        chk("i_out",      i_out,      exp_out);

        hs     = exp_valid && out_ready;
        psh    = in_valid && !m_sweep && (size0 < DEPTH);
        m_done = 1'b0;
        if (hs) begin
            if (m_sweep) begin
                m_done = (m_cnt == 2'd3);
                m_cnt  = m_cnt + 2'd1;
                if (!sweep_en) m_sweep = 1'b0;
            end else begin
                void'(sb_q.pop_front());
            end
        end else if (!m_sweep && sweep_en && size0 == 0) begin
            m_sweep = 1'b1;
        end
        if (psh) sb_q.push_back(dec({a, b}));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] ab, input logic ordy);
        in_valid  = v;
        {a, b}    = ab;
        out_ready = ordy;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"},  out_valid,  1'b0);
        chk({tag, "_i_out"},      i_out,      4'b0000);
        chk({tag, "_level"},      32'(level), 0);
        chk({tag, "_sweep_done"}, sweep_done, 1'b0);
        chk({tag, "_in_ready"},   in_ready,   1'b0);
    endtask

    initial begin
        // Power-on reset
        #2 rst = 1'b1;
        #1 reset_checks("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single push of (1,0) with downstream ready
        drive(1'b1, 2'b10, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b1);
        repeat (2) tick();

        // Fill to DEPTH with downstream stalled, then drain in order
        drive(1'b1, 2'b00, 1'b0); tick();
        drive(1'b1, 2'b01, 1'b0); tick();
        drive(1'b1, 2'b11, 1'b0); tick();
        drive(1'b1, 2'b10, 1'b0); tick();
        // Full: offered pair must be refused, even with a simultaneous pop
        drive(1'b1, 2'b11, 1'b0); tick();
        drive(1'b1, 2'b11, 1'b1); tick();
        drive(1'b0, 2'b00, 1'b1);
        repeat (5) tick();

        // Steady push+pop at level 2, pointers wrapping
        drive(1'b1, 2'b01, 1'b0); tick();
        drive(1'b1, 2'b10, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b1);
            tick();
        end
        drive(1'b0, 2'b00, 1'b1);
        repeat (3) tick();

        // Sweep from empty: two full rounds of 0001,0010,0100,1000
        sweep_en = 1'b1;
        repeat (10) tick();

        // Drop sweep_en while stalled: code held, one handshake, then back to FIFO
        drive(1'b0, 2'b00, 1'b0);
        sweep_en = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // Re-entered sweep resumes at the next code, with stalls mixed in
        sweep_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            out_ready = i[0];
            tick();
        end
        out_ready = 1'b1;
        sweep_en  = 1'b0;
        repeat (3) tick();

        // Asynchronous reset with three entries stored
        drive(1'b1, 2'b11, 1'b0); tick();
        drive(1'b1, 2'b01, 1'b0); tick();
        drive(1'b1, 2'b10, 1'b0); tick();
        drive(1'b0, 2'b00, 1'b0);
        #2 rst = 1'b1;
        #1 reset_checks("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        m_sweep = 1'b0;
        m_cnt   = 2'd0;
        m_done  = 1'b0;
        drive(1'b1, 2'b00, 1'b1);
        tick();
        drive(1'b0, 2'b00, 1'b1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
